// File: rtl/reduce_accum_block.sv
`default_nettype none
// ============================================================================
// Module   : reduce_accum_block
// Purpose  : Bitwise OR/AND/XOR reduction across NUM_IN lanes, registered,
//            with an optional sticky accumulate mode and saturating counter.
// Revision : 1.0
// ============================================================================
module reduce_accum_block #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [1:0]               mode,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_any,
    output logic [CNT_W-1:0]         acc_count
);

    localparam logic [1:0] c_MODE_OR  = 2'b00;
    localparam logic [1:0] c_MODE_AND = 2'b01;
    localparam logic [1:0] c_MODE_XOR = 2'b10;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;
    logic             r_empty;

    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_fold;
    logic             w_count_sat;

    // Reserved encoding 11 falls through to OR.
    function automatic logic [WIDTH-1:0] f_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            c_MODE_OR:  f_op = a | b;
            c_MODE_AND: f_op = a & b;
            c_MODE_XOR: f_op = a ^ b;
            default:    f_op = a | b;
        endcase
    endfunction

    always_comb begin
        w_red = in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            w_red = f_op(mode, w_red, in_data[k*WIDTH +: WIDTH]);
        end
    end

    assign w_fold      = f_op(mode, r_data, w_red);
    assign w_count_sat = &r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_empty <= 1'b1;
        end else begin
            // Every accepted sample produces exactly one out_valid pulse.
            r_valid <= in_valid;
            if (!acc_en) begin
                r_count <= '0;
                r_empty <= 1'b1;
                if (in_valid) begin
                    r_data <= w_red;
                end
            end else if (acc_clr) begin
                if (in_valid) begin
                    r_data  <= w_red;
                    r_count <= CNT_W'(1);
                    r_empty <= 1'b0;
                end else begin
                    r_data  <= '0;
                    r_count <= '0;
                    r_empty <= 1'b1;
                end
            end else if (in_valid) begin
                if (r_empty) begin
                    // First sample loads directly so AND accumulation starts correctly.
                    r_data  <= w_red;
                    r_count <= CNT_W'(1);
                    r_empty <= 1'b0;
                end else begin
                    r_data <= w_fold;
                    if (!w_count_sat) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_any   = |r_data;
    assign acc_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reduce_accum_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduce_accum_block
// Purpose  : Directed scoreboard bench; two DUTs share stimulus, differing
//            only in counter width (8 and 2 bits).
// Revision : 1.0
// ============================================================================
module tb_reduce_accum_block;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  mode = 2'b00;
    logic        acc_en = 1'b0;
    logic        acc_clr = 1'b0;

    logic        out_valid_a, out_any_a;
    logic [3:0]  out_data_a;
    logic [7:0]  acc_count_a;
    logic        out_valid_b, out_any_b;
    logic [3:0]  out_data_b;
    logic [1:0]  acc_count_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] m_data;
    logic [7:0] m_c8;
    logic [1:0] m_c2;
    logic       m_empty;

    reduce_accum_block #(.NUM_IN(4), .WIDTH(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid_a), .out_data(out_data_a),
        .out_any(out_any_a), .acc_count(acc_count_a)
    );

    reduce_accum_block #(.NUM_IN(4), .WIDTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid_b), .out_data(out_data_b),
        .out_any(out_any_b), .acc_count(acc_count_b)
    );

    always #5 clk = ~clk;

    // Reference reduction by counting ones per bit position.
    function automatic logic [3:0] ref_red(input logic [15:0] d, input logic [1:0] md);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            int ones;
            ones = 0;
            for (int l = 0; l < 4; l++) ones += int'(d[l*4+b]);
            case (md)
                2'b01:   r[b] = (ones == 4);
                2'b10:   r[b] = ones[0];
                default: r[b] = (ones != 0);
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] md);
        case (md)
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the model prediction, then pop and compare.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic [1:0] md, input logic en, input logic clr,
                        input string tag);
        exp_t e;
        exp_t got;
        logic [3:0] red;
        red = ref_red(d, md);
        e.v = 1'b0;
        if (r) begin
            m_data = '0; m_c8 = '0; m_c2 = '0; m_empty = 1'b1;
        end else if (!en) begin
            if (v) m_data = red;
            e.v = v; m_c8 = '0; m_c2 = '0; m_empty = 1'b1;
        end else if (clr && v) begin
            m_data = red; m_c8 = 8'd1; m_c2 = 2'd1; m_empty = 1'b0; e.v = 1'b1;
        end else if (clr) begin
            m_data = '0; m_c8 = '0; m_c2 = '0; m_empty = 1'b1;
        end else if (v && m_empty) begin
            m_data = red; m_c8 = 8'd1; m_c2 = 2'd1; m_empty = 1'b0; e.v = 1'b1;
        end else if (v) begin
            m_data = ref_op(m_data, red, md);
            if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
            if (m_c2 != 2'h3)  m_c2 = m_c2 + 2'd1;
            e.v = 1'b1;
        end
        e.d = m_data; e.c8 = m_c8; e.c2 = m_c2;
        sb_q.push_back(e);

        rst = r; in_valid = v; in_data = d; mode = md; acc_en = en; acc_clr = clr;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, "_valid_a"}, 32'(out_valid_a), 32'(got.v));
        chk({tag, "_data_a"},  32'(out_data_a),  32'(got.d));
        chk({tag, "_any_a"},   32'(out_any_a),   32'(|got.d));
        chk({tag, "_cnt_a"},   32'(acc_count_a), 32'(got.c8));
        chk({tag, "_valid_b"}, 32'(out_valid_b), 32'(got.v));
        chk({tag, "_data_b"},  32'(out_data_b),  32'(got.d));
        chk({tag, "_cnt_b"},   32'(acc_count_b), 32'(got.c2));
    endtask

    initial begin
        m_data = '0; m_c8 = '0; m_c2 = '0; m_empty = 1'b1;

        // Reset held with a valid, nonzero sample present.
        step(1, 1, 16'hFFFF, 2'b00, 0, 0, "rst0");
        step(1, 1, 16'h1234, 2'b00, 1, 0, "rst1");
        chk("plan_rst_data", 32'(out_data_a), 32'h0);
        chk("plan_rst_any",  32'(out_any_a),  32'h0);

        // Pass OR, then idle: out_data holds.
        step(0, 1, 16'h0421, 2'b00, 0, 0, "pass_or");
        chk("plan_pass_or", 32'(out_data_a), 32'h7);
        step(0, 0, 16'h0000, 2'b00, 0, 0, "pass_hold");
        chk("plan_pass_hold", 32'(out_data_a), 32'h7);

        // Pass AND / XOR on lanes {F,E,6,7}; acc_clr ignored in pass mode.
        step(0, 1, 16'h76EF, 2'b01, 0, 0, "pass_and");
        chk("plan_pass_and", 32'(out_data_a), 32'h6);
        step(0, 1, 16'h76EF, 2'b10, 0, 0, "pass_xor");
        chk("plan_pass_xor_any", 32'(out_any_a), 32'h0);
        step(0, 1, 16'h0003, 2'b11, 0, 0, "pass_rsvd");
        step(0, 0, 16'h0000, 2'b00, 0, 1, "pass_clr_ign");

        // Accumulate OR: reductions 1, 8, 0.
        step(0, 0, 16'h0000, 2'b00, 1, 1, "acc_clr");
        step(0, 1, 16'h0001, 2'b00, 1, 0, "acc_or1");
        step(0, 1, 16'h8000, 2'b00, 1, 0, "acc_or2");
        step(0, 1, 16'h0000, 2'b00, 1, 0, "acc_or3");
        chk("plan_acc_or_data", 32'(out_data_a),  32'h9);
        chk("plan_acc_or_cnt",  32'(acc_count_a), 32'd3);
        step(0, 0, 16'hFFFF, 2'b00, 1, 0, "acc_idle");

        // Leave to pass then re-enter: AND accumulation starts empty.
        step(0, 0, 16'h0000, 2'b00, 0, 0, "to_pass");
        step(0, 1, 16'hFFFF, 2'b01, 1, 0, "acc_and1");
        step(0, 1, 16'hD7F5, 2'b01, 1, 0, "acc_and2");
        chk("plan_acc_and", 32'(out_data_a), 32'h5);
        step(0, 1, 16'h000C, 2'b10, 1, 0, "acc_xor_mid");
        step(0, 1, 16'h2222, 2'b01, 1, 1, "acc_clr_v");
        chk("plan_clr_v_data", 32'(out_data_a),  32'h2);
        chk("plan_clr_v_cnt",  32'(acc_count_a), 32'd1);

        // Counter saturation on the 2-bit instance, then reset mid-stream.
        step(0, 0, 16'h0000, 2'b00, 1, 1, "sat_clr");
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 16'(1 << i), 2'b00, 1, 0, $sformatf("sat%0d", i));
        end
        chk("plan_sat_b", 32'(acc_count_b), 32'd3);
        chk("plan_sat_a", 32'(acc_count_a), 32'd5);
        step(1, 1, 16'hAAAA, 2'b00, 1, 0, "mid_rst");
        step(0, 1, 16'h0008, 2'b01, 1, 0, "post_rst");
        chk("plan_post_rst", 32'(out_data_a), 32'h0);
        step(0, 1, 16'h0030, 2'b00, 1, 0, "post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/reduce_accum_block.md
Name: reduce_accum_block

Overview:
- Parametrised successor to the team's fixed 4-input registered OR block.
- Reduces NUM_IN lanes of WIDTH bits bitwise with a selectable operator (OR/AND/XOR) and registers the result.
- Optional accumulate mode folds successive valid samples into a sticky result and counts them.
- Sits between raw status/flag sources and downstream control logic as a registered, valid-qualified flag aggregator.

Parameters:
- NUM_IN, 4, number of input lanes (legal 2..16)
- WIDTH, 1, bits per lane and output width (legal 1..32)
- CNT_W, 8, width of the saturating accumulated-sample counter (legal 2..16)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data and mode are sampled this cycle
- in_data  input  NUM_IN*WIDTH  lanes packed; lane k = in_data[k*WIDTH +: WIDTH]
- mode  input  2  00 OR, 01 AND, 10 XOR, 11 reserved (behaves as OR)
- acc_en  input  1  1 = accumulate mode, 0 = pass mode
- acc_clr  input  1  clear accumulator (single-cycle pulse)
- out_valid  output  1  out_data updated by a valid sample last cycle
- out_data  output  WIDTH  registered result
- out_any  output  1  |out_data, combinational from the register
- acc_count  output  CNT_W  number of samples folded since last clear, saturating

Behaviour:
- Reset (rst=1 at edge): out_data=0, out_valid=0, acc_count=0, internal empty flag=1. rst overrides all other inputs, including mid-accumulation.
- red = per-bit reduction across all NUM_IN lanes using the current mode. Combinational, same cycle as in_valid.
- Latency: 1 clk from in_valid to out_valid/out_data. No backpressure; a new sample may be presented every cycle.
- out_valid is 1 for exactly one cycle per accepted in_valid and is 0 otherwise. out_data holds its value when out_valid=0.
- Pass mode (acc_en=0):
  - in_valid: out_data<=red.
  - acc_count<=0 and empty<=1 every cycle.
  - acc_clr is ignored.
- Accumulate mode (acc_en=1), priority in order:
  - acc_clr & in_valid: out_data<=red, acc_count<=1, empty<=0, out_valid<=1. The new sample starts a fresh accumulation.
  - acc_clr only: out_data<=0, acc_count<=0, empty<=1, out_valid<=0.
  - in_valid & empty: out_data<=red, acc_count<=1, empty<=0.
  - in_valid & !empty: out_data<=out_data OP red, where OP is the current mode's operator. acc_count increments and saturates at 2^CNT_W-1. Saturation does not stop accumulation.
  - Otherwise: all state holds.
- Mode change mid-accumulation: the new operator applies from that sample onward. There is no implicit clear.
- Transition acc_en 1->0: the next cycle behaves as pass mode; the accumulated value is overwritten by the next valid sample.
- Transition acc_en 0->1: the accumulator starts empty, so the first sample loads directly. This makes AND accumulation correct.
- All outputs are driven from registers except out_any.
- No latches; no X on outputs after the first reset.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and nonzero data -> out_data=0, out_valid=0, acc_count=0, out_any=0.
- Pass OR, NUM_IN=4, WIDTH=4, lanes {1,2,4,0}, in_valid pulse -> next cycle out_data=0x7, out_valid=1, out_any=1. The cycle after -> out_valid=0, out_data holds 0x7.
- Pass AND then XOR, lanes {F,E,6,7} -> AND gives 0x6. XOR gives 0x0 with out_any=0.
- Accumulate OR: acc_clr pulse, then valid samples whose reductions are 0x1, 0x8, 0x0 -> out_data 0x1, 0x9, 0x9 and acc_count 1, 2, 3.
- Accumulate AND from empty, reductions 0xF then 0x5 -> out_data 0xF then 0x5. Then acc_clr with in_valid in the same cycle (reduction 0x2) -> out_data=0x2, acc_count=1.
- CNT_W=2: 5 consecutive accumulate samples -> acc_count 1, 2, 3, 3, 3. Then rst mid-stream -> all outputs 0 the next cycle, and the next sample loads as the first sample.
